// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: shared fade-state encoding and channel numbering for the RGB PWM fader.
package rgb_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } fade_state_e;

    localparam logic [1:0] CH_RED   = 2'd0;
    localparam logic [1:0] CH_GREEN = 2'd1;
    localparam logic [1:0] CH_BLUE  = 2'd2;
    localparam logic [1:0] CH_LAST  = 2'd2;

    // Channel rotation red -> green -> blue -> red; code 3 is never produced.
    function automatic logic [1:0] next_chan(input logic [1:0] ch);
        return (ch == CH_LAST) ? CH_RED : ch + 2'd1;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: free-running prescaler plus PWM frame counter, reusable by any LED stage.
module pwm_tick_gen #(
    parameter int PRESCALE = 12000,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                tick_o,
    output logic [PWM_BITS-1:0] pwm_cnt_o,
    output logic                frame_end_o
);

    localparam int                  PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PS_W-1:0]     presc_q, presc_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                frame_end_q, frame_end_d;
    logic                tick;

    // Prescaler wraps on tick, PWM counter steps on tick, frame end flagged on the last step of a frame
    always_comb begin
        tick        = (presc_q == PS_LAST);
        presc_d     = tick ? '0 : presc_q + 1'b1;
        cnt_d       = tick ? cnt_q + 1'b1 : cnt_q;
        frame_end_d = tick && (cnt_q == CNT_MAX);
    end

    // Counter registers; these keep running whatever the fader is doing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            cnt_q       <= '0;
            frame_end_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign tick_o      = tick;
    assign pwm_cnt_o   = cnt_q;
    assign frame_end_o = frame_end_q;

endmodule

// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: fades one RGB channel at a time up and down, producing glitch-free PWM for the LED driver.
module rgb_pwm_fader
    import rgb_pwm_pkg::*;
#(
    parameter int PRESCALE    = 12000,
    parameter int PWM_BITS    = 8,
    parameter int FADE_FRAMES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    output logic                pwm_r,
    output logic                pwm_g,
    output logic                pwm_b,
    output logic [1:0]          chan,
    output logic [PWM_BITS-1:0] level,
    output logic                frame_end
);

    localparam int                  FC_W     = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [FC_W-1:0]     FC_LAST  = FC_W'(FADE_FRAMES - 1);
    localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] LVL_PEAK = {{(PWM_BITS-1){1'b1}}, 1'b0};

    fade_state_e         state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [1:0]          chan_q, chan_d;
    logic [FC_W-1:0]     fcnt_q, fcnt_d;
    logic [2:0]          pwm_q, pwm_d;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                frame_end_int;
    logic                tick_unused;
    logic                step;

    pwm_tick_gen #(
        .PRESCALE (PRESCALE),
        .PWM_BITS (PWM_BITS)
    ) u_tick_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_o      (tick_unused),
        .pwm_cnt_o   (pwm_cnt),
        .frame_end_o (frame_end_int)
    );

    assign step = frame_end_int && (fcnt_q == FC_LAST);

    // Fade FSM: brightness and channel only move on a step, which always lands on a frame boundary
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        chan_d  = chan_q;
        fcnt_d  = fcnt_q;
        if (!enable) begin
            state_d = IDLE;
            level_d = '0;
            chan_d  = CH_RED;
            fcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = UP;
                    level_d = '0;
                    chan_d  = CH_RED;
                    fcnt_d  = '0;
                end
                UP, DOWN: begin
                    if (frame_end_int) begin
                        fcnt_d = (fcnt_q == FC_LAST) ? '0 : fcnt_q + 1'b1;
                    end
                    if (step && state_q == UP) begin
                        level_d = level_q + 1'b1;
                        if (level_q == LVL_PEAK) begin
                            state_d = DOWN;
                        end
                    end else if (step) begin
                        level_d = level_q - 1'b1;
                        if (level_q == LVL_ONE) begin
                            state_d = UP;
                            chan_d  = next_chan(chan_q);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = '0;
                    chan_d  = CH_RED;
                    fcnt_d  = '0;
                end
            endcase
        end
    end

    // PWM compare: only the active channel may be high, and only while fading
    always_comb begin
        pwm_d    = '0;
        pwm_d[0] = (state_q != IDLE) && (chan_q == CH_RED)   && (pwm_cnt < level_q);
        pwm_d[1] = (state_q != IDLE) && (chan_q == CH_GREEN) && (pwm_cnt < level_q);
        pwm_d[2] = (state_q != IDLE) && (chan_q == CH_BLUE)  && (pwm_cnt < level_q);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            level_q <= '0;
            chan_q  <= CH_RED;
            fcnt_q  <= '0;
            pwm_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            chan_q  <= chan_d;
            fcnt_q  <= fcnt_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_r     = pwm_q[0];
    assign pwm_g     = pwm_q[1];
    assign pwm_b     = pwm_q[2];
    assign chan      = chan_q;
    assign level     = level_q;
    assign frame_end = frame_end_int;

endmodule
